// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Package  : mips_ctrl_pkg
// Desc     : State, instruction-class and control-field encodings for the
//            multicycle MIPS main control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEXE  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IEXE   = 4'd9,
      S_IWB    = 4'd10,
      S_JUMP   = 4'd11,
      S_JAL    = 4'd12,
      S_JR     = 4'd13,
      S_EXC    = 4'd14
   } statetype;

   typedef enum logic [3:0] {
      CL_RTYPE, CL_JR, CL_LW, CL_LB, CL_LBU, CL_SW, CL_SB, CL_BEQ,
      CL_BNE, CL_ADDI, CL_ANDI, CL_ORI, CL_SLTI, CL_J, CL_JAL, CL_ILL
   } opclass_t;

   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_lb    = 6'b100000;
   localparam logic [5:0] c_op_lbu   = 6'b100100;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_sb    = 6'b101000;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_andi  = 6'b001100;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_slti  = 6'b001010;
   localparam logic [5:0] c_op_j     = 6'b000010;
   localparam logic [5:0] c_op_jal   = 6'b000011;
   localparam logic [5:0] c_funct_jr = 6'b001000;

   localparam logic [2:0] c_alu_add   = 3'b000;
   localparam logic [2:0] c_alu_sub   = 3'b001;
   localparam logic [2:0] c_alu_funct = 3'b010;
   localparam logic [2:0] c_alu_and   = 3'b011;
   localparam logic [2:0] c_alu_or    = 3'b100;
   localparam logic [2:0] c_alu_slt   = 3'b101;

   localparam logic [1:0] c_rd_rt = 2'b00;
   localparam logic [1:0] c_rd_rd = 2'b01;
   localparam logic [1:0] c_rd_ra = 2'b10;

   localparam logic [1:0] c_m2r_alu = 2'b00;
   localparam logic [1:0] c_m2r_mdr = 2'b01;
   localparam logic [1:0] c_m2r_pc  = 2'b10;

   localparam logic [1:0] c_pc_alu    = 2'b00;
   localparam logic [1:0] c_pc_aluout = 2'b01;
   localparam logic [1:0] c_pc_jump   = 2'b10;
   localparam logic [1:0] c_pc_a      = 2'b11;

   localparam logic [1:0] c_srcb_b    = 2'b00;
   localparam logic [1:0] c_srcb_4    = 2'b01;
   localparam logic [1:0] c_srcb_imm  = 2'b10;
   localparam logic [1:0] c_srcb_imm2 = 2'b11;

   function automatic logic is_store(opclass_t c);
      return (c == CL_SW) || (c == CL_SB);
   endfunction

   function automatic logic is_byte_load(opclass_t c);
      return (c == CL_LB) || (c == CL_LBU);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_opclass.sv
// ============================================================================
// Module   : mips_ctrl_opclass
// Desc     : Combinational op/funct to instruction-class decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_opclass
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output opclass_t   opclass
);

   always_comb begin
      opclass = CL_ILL;
      case (op)
         c_op_rtype: opclass = (funct == c_funct_jr) ? CL_JR : CL_RTYPE;
         c_op_lw:    opclass = CL_LW;
         c_op_lb:    opclass = CL_LB;
         c_op_lbu:   opclass = CL_LBU;
         c_op_sw:    opclass = CL_SW;
         c_op_sb:    opclass = CL_SB;
         c_op_beq:   opclass = CL_BEQ;
         c_op_bne:   opclass = CL_BNE;
         c_op_addi:  opclass = CL_ADDI;
         c_op_andi:  opclass = CL_ANDI;
         c_op_ori:   opclass = CL_ORI;
         c_op_slti:  opclass = CL_SLTI;
         c_op_j:     opclass = CL_J;
         c_op_jal:   opclass = CL_JAL;
         default:    opclass = CL_ILL;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mips_mc_ctrl_fsm.sv
// ============================================================================
// Module   : mips_mc_ctrl_fsm
// Desc     : Multicycle MIPS main control FSM with req/ready memory handshake,
//            bounded wait and sticky trap state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mc_ctrl_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int EN_WAIT = 1,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       branch,
   output logic       bne,
   output logic       regwrite,
   output logic [1:0] regdst,
   output logic [1:0] memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       zext,
   output logic [1:0] pcsrc,
   output logic [2:0] aluop,
   output logic       ldbyte,
   output logic       ldsign,
   output logic       stbyte,
   output logic       exc,
   output logic [3:0] st
);

   localparam int              c_cw  = $clog2(TIMEOUT + 1);
   localparam logic [c_cw-1:0] c_tmo = c_cw'(TIMEOUT);
   localparam logic [c_cw-1:0] c_one = c_cw'(1);

   statetype        r_state;
   statetype        w_next;
   logic [c_cw-1:0] r_wcnt;
   opclass_t        w_cls;
   logic            w_ready;
   logic            w_memstate;
   logic            w_timeout;

   mips_ctrl_opclass u_opclass (
      .op      (op),
      .funct   (funct),
      .opclass (w_cls)
   );

   generate
      if (EN_WAIT != 0) begin : g_wait
         assign w_ready = mem_ready;
      end else begin : g_nowait
         assign w_ready = 1'b1;
      end
   endgenerate

   assign w_memstate = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout  = w_memstate && !w_ready && (r_wcnt == c_tmo);
   assign st         = r_state;

   // Counter only runs while a memory state is stalled; any state change clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_next;
         if (w_memstate && !w_ready && (w_next == r_state))
            r_wcnt <= r_wcnt + c_one;
         else
            r_wcnt <= '0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (w_timeout)    w_next = S_EXC;
            else if (w_ready) w_next = S_DECODE;
         end
         S_DECODE: begin
            case (w_cls)
               CL_RTYPE:                             w_next = S_RTEXE;
               CL_JR:                                w_next = S_JR;
               CL_LW, CL_LB, CL_LBU, CL_SW, CL_SB:   w_next = S_MEMADR;
               CL_BEQ, CL_BNE:                       w_next = S_BRANCH;
               CL_ADDI, CL_ANDI, CL_ORI, CL_SLTI:    w_next = S_IEXE;
               CL_J:                                 w_next = S_JUMP;
               CL_JAL:                               w_next = S_JAL;
               default:                              w_next = S_EXC;
            endcase
         end
         S_MEMADR: w_next = is_store(w_cls) ? S_MEMWR : S_MEMRD;
         S_MEMRD: begin
            if (w_timeout)    w_next = S_EXC;
            else if (w_ready) w_next = S_MEMWB;
         end
         S_MEMWR: begin
            if (w_timeout)    w_next = S_EXC;
            else if (w_ready) w_next = S_FETCH;
         end
         S_RTEXE:  w_next = S_ALUWB;
         S_IEXE:   w_next = S_IWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_IWB, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
         S_EXC:    w_next = S_EXC;
         default:  w_next = S_EXC;
      endcase
   end

   always_comb begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      iord     = 1'b0;
      irwrite  = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      regwrite = 1'b0;
      regdst   = c_rd_rt;
      memtoreg = c_m2r_alu;
      alusrca  = 1'b0;
      alusrcb  = c_srcb_b;
      zext     = 1'b0;
      pcsrc    = c_pc_alu;
      aluop    = c_alu_add;
      ldbyte   = 1'b0;
      ldsign   = 1'b0;
      stbyte   = 1'b0;
      exc      = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            alusrcb = c_srcb_4;
            irwrite = w_ready;
            pcwrite = w_ready;
         end
         S_DECODE: alusrcb = c_srcb_imm2;
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = c_srcb_imm;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            ldbyte  = is_byte_load(w_cls);
            ldsign  = (w_cls == CL_LB);
         end
         S_MEMWB: begin
            regwrite = 1'b1;
            memtoreg = c_m2r_mdr;
            ldbyte   = is_byte_load(w_cls);
            ldsign   = (w_cls == CL_LB);
         end
         S_MEMWR: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            stbyte   = (w_cls == CL_SB);
            memwrite = w_ready;
         end
         S_RTEXE: begin
            alusrca = 1'b1;
            aluop   = c_alu_funct;
         end
         S_ALUWB: begin
            regwrite = 1'b1;
            regdst   = c_rd_rd;
         end
         S_BRANCH: begin
            alusrca = 1'b1;
            aluop   = c_alu_sub;
            pcsrc   = c_pc_aluout;
            branch  = (w_cls == CL_BEQ);
            bne     = (w_cls == CL_BNE);
         end
         S_IEXE: begin
            alusrca = 1'b1;
            alusrcb = c_srcb_imm;
            zext    = (w_cls == CL_ANDI) || (w_cls == CL_ORI);
            case (w_cls)
               CL_ANDI: aluop = c_alu_and;
               CL_ORI:  aluop = c_alu_or;
               CL_SLTI: aluop = c_alu_slt;
               default: aluop = c_alu_add;
            endcase
         end
         S_IWB: begin
            regwrite = 1'b1;
            zext     = (w_cls == CL_ANDI) || (w_cls == CL_ORI);
         end
         S_JUMP: begin
            pcsrc   = c_pc_jump;
            pcwrite = 1'b1;
         end
         // PC already holds PC+4 from FETCH, so it is the link value.
         S_JAL: begin
            pcsrc    = c_pc_jump;
            pcwrite  = 1'b1;
            regwrite = 1'b1;
            regdst   = c_rd_ra;
            memtoreg = c_m2r_pc;
         end
         S_JR: begin
            pcsrc   = c_pc_a;
            pcwrite = 1'b1;
         end
         S_EXC:   exc = 1'b1;
         default: exc = 1'b0;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mips_mc_ctrl_fsm.sv
// ============================================================================
// Module   : tb_mips_mc_ctrl_fsm
// Desc     : Random instruction-stream scoreboard bench for mips_mc_ctrl_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mc_ctrl_fsm;

   typedef struct packed {
      logic mem_req, memwrite, iord, irwrite, pcwrite, branch, bne, regwrite;
      logic [1:0] regdst, memtoreg;
      logic alusrca;
      logic [1:0] alusrcb;
      logic zext;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic ldbyte, ldsign, stbyte, exc;
      logic [3:0] st;
   } ov_t;

   typedef enum int {K_R, K_JR, K_LW, K_LB, K_LBU, K_SW, K_SB, K_BEQ, K_BNE,
                     K_ADDI, K_ANDI, K_ORI, K_SLTI, K_J, K_JAL, K_ILL} kind_t;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_RTEXE = 6, S_ALUWB = 7, S_BRANCH = 8, S_IEXE = 9,
                  S_IWB = 10, S_JUMP = 11, S_JAL = 12, S_JR = 13, S_EXC = 14;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] op, funct;
   logic       mem_ready;

   logic       w_mem_req, w_memwrite, w_iord, w_irwrite, w_pcwrite, w_branch, w_bne, w_regwrite;
   logic [1:0] w_regdst, w_memtoreg, w_alusrcb, w_pcsrc;
   logic       w_alusrca, w_zext, w_ldbyte, w_ldsign, w_stbyte, w_exc;
   logic [2:0] w_aluop;
   logic [3:0] w_st;
   logic       z_mem_req, z_memwrite, z_iord, z_irwrite, z_pcwrite, z_branch, z_bne, z_regwrite;
   logic [1:0] z_regdst, z_memtoreg, z_alusrcb, z_pcsrc;
   logic       z_alusrca, z_zext, z_ldbyte, z_ldsign, z_stbyte, z_exc;
   logic [2:0] z_aluop;
   logic [3:0] z_st;

   int  errors = 0;
   int  checks = 0;
   bit  sel_z  = 1'b0;
   int  en_wait = 1;
   int  tmo     = 4;
   ov_t expq[$];
   ov_t act_w, act_z;

   always #5 clk = ~clk;

   mips_mc_ctrl_fsm #(.EN_WAIT(1), .TIMEOUT(4)) u_dut_w (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .mem_req(w_mem_req), .memwrite(w_memwrite), .iord(w_iord), .irwrite(w_irwrite),
      .pcwrite(w_pcwrite), .branch(w_branch), .bne(w_bne), .regwrite(w_regwrite),
      .regdst(w_regdst), .memtoreg(w_memtoreg), .alusrca(w_alusrca), .alusrcb(w_alusrcb),
      .zext(w_zext), .pcsrc(w_pcsrc), .aluop(w_aluop), .ldbyte(w_ldbyte), .ldsign(w_ldsign),
      .stbyte(w_stbyte), .exc(w_exc), .st(w_st));

   mips_mc_ctrl_fsm #(.EN_WAIT(0), .TIMEOUT(15)) u_dut_z (
      .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .mem_ready(mem_ready),
      .mem_req(z_mem_req), .memwrite(z_memwrite), .iord(z_iord), .irwrite(z_irwrite),
      .pcwrite(z_pcwrite), .branch(z_branch), .bne(z_bne), .regwrite(z_regwrite),
      .regdst(z_regdst), .memtoreg(z_memtoreg), .alusrca(z_alusrca), .alusrcb(z_alusrcb),
      .zext(z_zext), .pcsrc(z_pcsrc), .aluop(z_aluop), .ldbyte(z_ldbyte), .ldsign(z_ldsign),
      .stbyte(z_stbyte), .exc(z_exc), .st(z_st));

   assign act_w = {w_mem_req, w_memwrite, w_iord, w_irwrite, w_pcwrite, w_branch, w_bne,
                   w_regwrite, w_regdst, w_memtoreg, w_alusrca, w_alusrcb, w_zext, w_pcsrc,
                   w_aluop, w_ldbyte, w_ldsign, w_stbyte, w_exc, w_st};
   assign act_z = {z_mem_req, z_memwrite, z_iord, z_irwrite, z_pcwrite, z_branch, z_bne,
                   z_regwrite, z_regdst, z_memtoreg, z_alusrca, z_alusrcb, z_zext, z_pcsrc,
                   z_aluop, z_ldbyte, z_ldsign, z_stbyte, z_exc, z_st};

   // Expected control word for one cycle, straight from the per-state output table.
   function automatic ov_t expect_of(int s, kind_t k, logic rdy);
      ov_t o;
      o    = '0;
      o.st = 4'(s);
      case (s)
         S_FETCH:  begin o.mem_req = 1; o.alusrcb = 2'b01; o.irwrite = rdy; o.pcwrite = rdy; end
         S_DECODE: o.alusrcb = 2'b11;
         S_MEMADR: begin o.alusrca = 1; o.alusrcb = 2'b10; end
         S_MEMRD:  begin o.mem_req = 1; o.iord = 1; o.ldbyte = (k == K_LB || k == K_LBU); o.ldsign = (k == K_LB); end
         S_MEMWB:  begin o.regwrite = 1; o.memtoreg = 2'b01; o.ldbyte = (k == K_LB || k == K_LBU); o.ldsign = (k == K_LB); end
         S_MEMWR:  begin o.mem_req = 1; o.iord = 1; o.stbyte = (k == K_SB); o.memwrite = rdy; end
         S_RTEXE:  begin o.alusrca = 1; o.aluop = 3'b010; end
         S_ALUWB:  begin o.regwrite = 1; o.regdst = 2'b01; end
         S_BRANCH: begin o.alusrca = 1; o.aluop = 3'b001; o.pcsrc = 2'b01; o.branch = (k == K_BEQ); o.bne = (k == K_BNE); end
         S_IEXE: begin
            o.alusrca = 1; o.alusrcb = 2'b10; o.zext = (k == K_ANDI || k == K_ORI);
            o.aluop = (k == K_ANDI) ? 3'b011 : (k == K_ORI) ? 3'b100 : (k == K_SLTI) ? 3'b101 : 3'b000;
         end
         S_IWB:    begin o.regwrite = 1; o.zext = (k == K_ANDI || k == K_ORI); end
         S_JUMP:   begin o.pcsrc = 2'b10; o.pcwrite = 1; end
         S_JAL:    begin o.pcsrc = 2'b10; o.pcwrite = 1; o.regwrite = 1; o.regdst = 2'b10; o.memtoreg = 2'b10; end
         S_JR:     begin o.pcsrc = 2'b11; o.pcwrite = 1; end
         S_EXC:    o.exc = 1;
         default:  o = '0;
      endcase
      return o;
   endfunction

   function automatic logic [5:0] op_of(kind_t k);
      case (k)
         K_LW:   return 6'b100011;
         K_LB:   return 6'b100000;
         K_LBU:  return 6'b100100;
         K_SW:   return 6'b101011;
         K_SB:   return 6'b101000;
         K_BEQ:  return 6'b000100;
         K_BNE:  return 6'b000101;
         K_ADDI: return 6'b001000;
         K_ANDI: return 6'b001100;
         K_ORI:  return 6'b001101;
         K_SLTI: return 6'b001010;
         K_J:    return 6'b000010;
         K_JAL:  return 6'b000011;
         default: return 6'b000000;
      endcase
   endfunction

   function automatic logic [5:0] rand_illegal();
      logic [5:0] o;
      bit         legal;
      do begin
         o     = 6'($urandom);
         legal = 1'b0;
         for (int i = 0; i < 15; i++)
            if (op_of(kind_t'(i)) == o) legal = 1'b1;
      end while (legal);
      return o;
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int pick_delay();
      if ($urandom_range(0, 7) == 0) return tmo + 1 + int'($urandom_range(0, 2));
      return int'($urandom_range(0, tmo));
   endfunction

   task automatic check(string name, ov_t act, ov_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      ov_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         check($sformatf("state%0d", e.st), sel_z ? act_z : act_w, e);
      end
   end

   task automatic step(int s, kind_t k, logic rdy);
      logic eff;
      mem_ready = rdy;
      eff = (en_wait != 0) ? rdy : 1'b1;
      expq.push_back(expect_of(s, k, eff));
      @(posedge clk);
      #1;
   endtask

   // One memory state: ready rises after d stalled cycles, or the access traps.
   task automatic access(int s, kind_t k, int d, output bit ok);
      logic r;
      ok = 1'b0;
      if (en_wait == 0) begin
         step(s, k, 1'b0);
         ok = 1'b1;
         return;
      end
      for (int c = 0; c <= tmo; c++) begin
         r = (c == d);
         step(s, k, r);
         if (r) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic do_reset();
      logic eff;
      reset_n = 1'b0;
      #1;
      eff = (en_wait != 0) ? mem_ready : 1'b1;
      check("async_reset", sel_z ? act_z : act_w, expect_of(S_FETCH, K_ILL, eff));
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic exc_tail(int n);
      for (int i = 0; i < n; i++) begin
         op = 6'($urandom);
         step(S_EXC, K_ILL, rnd1());
      end
      do_reset();
   endtask

   // d_f / d_m < 0 pick a random ready delay for the fetch / data access.
   task automatic run_instr(kind_t k, logic [5:0] ill_op, int d_f, int d_m);
      bit ok;
      op = (k == K_ILL) ? ill_op : op_of(k);
      if (k == K_JR) funct = 6'b001000;
      else begin
         do funct = 6'($urandom); while (k == K_R && funct == 6'b001000);
      end
      access(S_FETCH, k, (d_f < 0) ? pick_delay() : d_f, ok);
      if (!ok) begin exc_tail(3); return; end
      step(S_DECODE, k, rnd1());
      case (k)
         K_R:    begin step(S_RTEXE, k, rnd1()); step(S_ALUWB, k, rnd1()); end
         K_JR:   step(S_JR, k, rnd1());
         K_LW, K_LB, K_LBU: begin
            step(S_MEMADR, k, rnd1());
            access(S_MEMRD, k, (d_m < 0) ? pick_delay() : d_m, ok);
            if (!ok) begin exc_tail(3); return; end
            step(S_MEMWB, k, rnd1());
         end
         K_SW, K_SB: begin
            step(S_MEMADR, k, rnd1());
            access(S_MEMWR, k, (d_m < 0) ? pick_delay() : d_m, ok);
            if (!ok) begin exc_tail(3); return; end
         end
         K_BEQ, K_BNE: step(S_BRANCH, k, rnd1());
         K_ADDI, K_ANDI, K_ORI, K_SLTI: begin step(S_IEXE, k, rnd1()); step(S_IWB, k, rnd1()); end
         K_J:    step(S_JUMP, k, rnd1());
         K_JAL:  step(S_JAL, k, rnd1());
         default: exc_tail(22);
      endcase
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      op        = 6'd0;
      funct     = 6'd0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1;

      // Waiting memory, TIMEOUT=4
      sel_z = 1'b0; en_wait = 1; tmo = 4;
      do_reset();
      run_instr(K_LW, 6'd0, 2, 2);
      run_instr(K_JAL, 6'd0, 0, 0);
      run_instr(K_JR, 6'd0, 1, 0);
      run_instr(K_ILL, 6'b111111, 0, 0);
      run_instr(K_SW, 6'd0, 0, 5);
      run_instr(K_SW, 6'd0, 0, 4);
      run_instr(K_ANDI, 6'd0, 0, 0);
      run_instr(K_ORI, 6'd0, 0, 0);
      run_instr(K_SLTI, 6'd0, 0, 0);
      run_instr(K_LB, 6'd0, 3, 1);
      run_instr(K_SB, 6'd0, 0, 2);
      run_instr(K_LW, 6'd0, 5, 0);
      // Reset while a load is stalled in MEMRD
      op = op_of(K_LW);
      step(S_FETCH, K_LW, 1'b1);
      step(S_DECODE, K_LW, 1'b0);
      step(S_MEMADR, K_LW, 1'b0);
      step(S_MEMRD, K_LW, 1'b0);
      step(S_MEMRD, K_LW, 1'b0);
      do_reset();
      for (int i = 0; i < 150; i++) begin
         kind_t k;
         k = kind_t'($urandom_range(0, 15));
         run_instr(k, rand_illegal(), -1, -1);
      end

      // Zero-wait memory
      sel_z = 1'b1; en_wait = 0; tmo = 15;
      do_reset();
      run_instr(K_SW, 6'd0, 0, 0);
      run_instr(K_LB, 6'd0, 0, 0);
      run_instr(K_SB, 6'd0, 0, 0);
      run_instr(K_ANDI, 6'd0, 0, 0);
      for (int i = 0; i < 100; i++) begin
         kind_t k;
         k = kind_t'($urandom_range(0, 15));
         run_instr(k, rand_illegal(), -1, -1);
      end

      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected cycles left unchecked, required 0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
